// File: rtl/ddr3_pkg.sv
// Shared DDR3 sequencer definitions used by the write- and read-side address generators.
package ddr3_pkg;

  localparam int unsigned DDR3_ADDR_W     = 26;
  localparam int unsigned DDR3_BURST_STEP = 8;

  localparam logic [2:0] DDR3_CMD_WRITE = 3'b000;
  localparam logic [2:0] DDR3_CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } ddr3_state_e;

endpackage

// File: rtl/ddr3_addr_wrap_ctr.sv
// Circular-buffer address counter: clear, load or step by STEP, wrapping to 0 at LIMIT.
module ddr3_addr_wrap_ctr #(
  parameter int unsigned W     = 26,
  parameter int unsigned STEP  = 8,
  parameter int unsigned LIMIT = 67108864
) (
  input  logic         clk,
  input  logic         reset_i,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  localparam int unsigned SW = W + 1;

  logic [W-1:0] count_q, count_d;
  logic [W:0]   sum_c;

  // Next count: clear wins over load, load wins over increment; one extra adder bit detects the wrap.
  always_comb begin
    sum_c   = {1'b0, count_q} + SW'(STEP);
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      count_d = (sum_c >= SW'(LIMIT)) ? '0 : sum_c[W-1:0];
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ddr3_write_addr_gen.sv
// Write-side DDR3 command sequencer: issues one write request per ready burst and
// walks a persistent circular write pointer across fills.
module ddr3_write_addr_gen
  import ddr3_pkg::*;
#(
  parameter int unsigned ADDR_W     = DDR3_ADDR_W,
  parameter int unsigned CNT_W      = 23,
  parameter int unsigned ADDR_STEP  = DDR3_BURST_STEP,
  parameter int unsigned ADDR_LIMIT = 67108864
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acq_enabled,
  input  logic              fill_start,
  input  logic [CNT_W-1:0]  burst_count,
  input  logic              wdata_avail,
  input  logic              addr_clear,
  input  logic              wr_app_rdy,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_app_en,
  output logic              wr_mode,
  output logic [ADDR_W-1:0] fill_base_addr,
  output logic              fill_done,
  output logic              fill_abort,
  output logic              start_err
);

  ddr3_state_e       state_q, state_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              en_q, en_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic              err_q, err_d;
  logic              addr_clr_c;
  logic              addr_inc_c;

  // Write pointer; persists across fills, only reset or an idle clear returns it to 0.
  ddr3_addr_wrap_ctr #(
    .W     (ADDR_W),
    .STEP  (ADDR_STEP),
    .LIMIT (ADDR_LIMIT)
  ) u_addr_ctr (
    .clk        (clk),
    .reset_i    (reset),
    .clear_i    (addr_clr_c),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (addr_inc_c),
    .count_o    (wr_addr)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    en_d        = en_q;
    base_d      = base_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    err_d       = err_q;
    addr_clr_c  = 1'b0;
    addr_inc_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        en_d = 1'b0;
        if (addr_clear) begin
          addr_clr_c = 1'b1;
        end
        if (fill_start && acq_enabled) begin
          remaining_d = burst_count;
          base_d      = addr_clear ? '0 : wr_addr;
          if (burst_count == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        if (fill_start) begin
          err_d = 1'b1;
        end
        if (!acq_enabled) begin
          // Mux has already dropped the command and gated rdy: nothing is counted.
          state_d = ST_IDLE;
          abort_d = 1'b1;
          en_d    = 1'b0;
        end else if (en_q) begin
          if (wr_app_rdy) begin
            addr_inc_c  = 1'b1;
            remaining_d = remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              en_d    = 1'b0;
            end else begin
              en_d = wdata_avail;
            end
          end
        end else begin
          en_d = wdata_avail && (remaining_q != '0);
        end
      end

      ST_DONE: begin
        if (fill_start) begin
          err_d = 1'b1;
        end
        en_d    = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        en_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    mode_d = (state_d == ST_WRITE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      en_q        <= 1'b0;
      mode_q      <= 1'b0;
      base_q      <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      en_q        <= en_d;
      mode_q      <= mode_d;
      base_q      <= base_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      err_q       <= err_d;
    end
  end

  assign wr_app_en      = en_q;
  assign wr_mode        = mode_q;
  assign fill_base_addr = base_q;
  assign fill_done      = done_q;
  assign fill_abort     = abort_q;
  assign start_err      = err_q;

endmodule

// File: tb/tb_ddr3_write_addr_gen.sv
// Directed bench for ddr3_write_addr_gen with a 64-byte wrap point.
module tb_ddr3_write_addr_gen;

  localparam int unsigned AW = 26;
  localparam int unsigned CW = 23;

  logic          clk = 1'b0;
  logic          reset;
  logic          acq_enabled;
  logic          fill_start;
  logic [CW-1:0] burst_count;
  logic          wdata_avail;
  logic          addr_clear;
  logic          wr_app_rdy;
  logic [AW-1:0] wr_addr;
  logic          wr_app_en;
  logic          wr_mode;
  logic [AW-1:0] fill_base_addr;
  logic          fill_done;
  logic          fill_abort;
  logic          start_err;

  // {wr_app_en, wr_mode, fill_done, fill_abort, start_err}
  logic [4:0]    flags;
  assign flags = {wr_app_en, wr_mode, fill_done, fill_abort, start_err};

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  ddr3_write_addr_gen #(
    .ADDR_W     (AW),
    .CNT_W      (CW),
    .ADDR_STEP  (8),
    .ADDR_LIMIT (64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .acq_enabled    (acq_enabled),
    .fill_start     (fill_start),
    .burst_count    (burst_count),
    .wdata_avail    (wdata_avail),
    .addr_clear     (addr_clear),
    .wr_app_rdy     (wr_app_rdy),
    .wr_addr        (wr_addr),
    .wr_app_en      (wr_app_en),
    .wr_mode        (wr_mode),
    .fill_base_addr (fill_base_addr),
    .fill_done      (fill_done),
    .fill_abort     (fill_abort),
    .start_err      (start_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fill(input int unsigned n);
    burst_count = CW'(n);
    acq_enabled = 1'b1;
    fill_start  = 1'b1;
    tick();
    fill_start  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; acq_enabled = 1'b0; fill_start = 1'b0; burst_count = '0;
    wdata_avail = 1'b0; addr_clear = 1'b0; wr_app_rdy = 1'b0;
    repeat (2) tick();
    vec_cnt++;
    if ({flags, wr_addr, fill_base_addr} !== {5'b00000, 26'd0, 26'd0}) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %h expected 0", {flags, wr_addr, fill_base_addr});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    wdata_avail = 1'b1; wr_app_rdy = 1'b1;
    start_fill(4);
    vec_cnt++;
    if ({flags, wr_addr, fill_base_addr} !== {5'b01000, 26'd0, 26'd0}) begin
      err_cnt++;
      $display("FAIL basic_enter: got %h expected %h", {flags, wr_addr, fill_base_addr}, {5'b01000, 26'd0, 26'd0});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vec_cnt++;
      if ({flags, wr_addr} !== {5'b11000, AW'(i * 8)}) begin
        err_cnt++;
        $display("FAIL basic_cmd%0d: got %h expected %h", i, {flags, wr_addr}, {5'b11000, AW'(i * 8)});
      end
    end
    tick();
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b00100, 26'd32}) begin
      err_cnt++;
      $display("FAIL basic_done: got %h expected %h", {flags, wr_addr}, {5'b00100, 26'd32});
    end
    tick();
    vec_cnt++;
    if ({flags, wr_addr, fill_base_addr} !== {5'b00000, 26'd32, 26'd0}) begin
      err_cnt++;
      $display("FAIL basic_idle: got %h expected %h", {flags, wr_addr, fill_base_addr}, {5'b00000, 26'd32, 26'd0});
    end
  endtask

  task automatic test_backpressure();
    start_fill(3);
    tick();
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b11000, 26'd32}) begin
      err_cnt++;
      $display("FAIL bp_first: got %h expected %h", {flags, wr_addr}, {5'b11000, 26'd32});
    end
    tick();
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b11000, 26'd40}) begin
      err_cnt++;
      $display("FAIL bp_second: got %h expected %h", {flags, wr_addr}, {5'b11000, 26'd40});
    end
    wr_app_rdy = 1'b0; wdata_avail = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++;
      if ({flags, wr_addr} !== {5'b11000, 26'd40}) begin
        err_cnt++;
        $display("FAIL bp_hold%0d: got %h expected %h", i, {flags, wr_addr}, {5'b11000, 26'd40});
      end
    end
    wr_app_rdy = 1'b1;
    tick();
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b01000, 26'd48}) begin
      err_cnt++;
      $display("FAIL bp_release: got %h expected %h", {flags, wr_addr}, {5'b01000, 26'd48});
    end
    wdata_avail = 1'b1;
    tick();
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b11000, 26'd48}) begin
      err_cnt++;
      $display("FAIL bp_resume: got %h expected %h", {flags, wr_addr}, {5'b11000, 26'd48});
    end
    tick();
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b00100, 26'd56}) begin
      err_cnt++;
      $display("FAIL bp_done: got %h expected %h", {flags, wr_addr}, {5'b00100, 26'd56});
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [AW-1:0] wrap_exp [4];
    wrap_exp = '{26'd48, 26'd56, 26'd0, 26'd8};
    addr_clear = 1'b1;
    tick();
    addr_clear = 1'b0;
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b00000, 26'd0}) begin
      err_cnt++;
      $display("FAIL addr_clear: got %h expected %h", {flags, wr_addr}, {5'b00000, 26'd0});
    end
    start_fill(6);
    repeat (7) tick();
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b00100, 26'd48}) begin
      err_cnt++;
      $display("FAIL wrap_preload: got %h expected %h", {flags, wr_addr}, {5'b00100, 26'd48});
    end
    tick();
    start_fill(4);
    vec_cnt++;
    if (fill_base_addr !== 26'd48) begin
      err_cnt++;
      $display("FAIL wrap_base: got %0d expected 48", fill_base_addr);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vec_cnt++;
      if ({flags, wr_addr} !== {5'b11000, wrap_exp[i]}) begin
        err_cnt++;
        $display("FAIL wrap_cmd%0d: got %h expected %h", i, {flags, wr_addr}, {5'b11000, wrap_exp[i]});
      end
    end
    tick();
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b00100, 26'd16}) begin
      err_cnt++;
      $display("FAIL wrap_done: got %h expected %h", {flags, wr_addr}, {5'b00100, 26'd16});
    end
    tick();
  endtask

  task automatic test_abort();
    addr_clear = 1'b1;
    start_fill(10);
    addr_clear = 1'b0;
    vec_cnt++;
    if ({flags, wr_addr, fill_base_addr} !== {5'b01000, 26'd0, 26'd0}) begin
      err_cnt++;
      $display("FAIL clear_and_start: got %h expected %h", {flags, wr_addr, fill_base_addr}, {5'b01000, 26'd0, 26'd0});
    end
    repeat (4) tick();
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b11000, 26'd24}) begin
      err_cnt++;
      $display("FAIL abort_pre: got %h expected %h", {flags, wr_addr}, {5'b11000, 26'd24});
    end
    acq_enabled = 1'b0;
    tick();
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b00010, 26'd24}) begin
      err_cnt++;
      $display("FAIL abort_pulse: got %h expected %h", {flags, wr_addr}, {5'b00010, 26'd24});
    end
    tick();
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b00000, 26'd24}) begin
      err_cnt++;
      $display("FAIL abort_idle: got %h expected %h", {flags, wr_addr}, {5'b00000, 26'd24});
    end
    start_fill(2);
    vec_cnt++;
    if (fill_base_addr !== 26'd24) begin
      err_cnt++;
      $display("FAIL abort_refill_base: got %0d expected 24", fill_base_addr);
    end
    tick();
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b11000, 26'd24}) begin
      err_cnt++;
      $display("FAIL abort_refill_cmd: got %h expected %h", {flags, wr_addr}, {5'b11000, 26'd24});
    end
    repeat (2) tick();
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b00100, 26'd40}) begin
      err_cnt++;
      $display("FAIL abort_refill_done: got %h expected %h", {flags, wr_addr}, {5'b00100, 26'd40});
    end
    tick();
  endtask

  task automatic test_zero_and_err();
    acq_enabled = 1'b0; burst_count = CW'(3); fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b00000, 26'd40}) begin
      err_cnt++;
      $display("FAIL start_no_acq: got %h expected %h", {flags, wr_addr}, {5'b00000, 26'd40});
    end
    start_fill(0);
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b00100, 26'd40}) begin
      err_cnt++;
      $display("FAIL zero_done: got %h expected %h", {flags, wr_addr}, {5'b00100, 26'd40});
    end
    tick();
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b00000, 26'd40}) begin
      err_cnt++;
      $display("FAIL zero_idle: got %h expected %h", {flags, wr_addr}, {5'b00000, 26'd40});
    end
    start_fill(2);
    burst_count = CW'(5); fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b11001, 26'd40}) begin
      err_cnt++;
      $display("FAIL err_set: got %h expected %h", {flags, wr_addr}, {5'b11001, 26'd40});
    end
    repeat (2) tick();
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b00101, 26'd56}) begin
      err_cnt++;
      $display("FAIL err_fill_done: got %h expected %h", {flags, wr_addr}, {5'b00101, 26'd56});
    end
    tick();
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b00001, 26'd56}) begin
      err_cnt++;
      $display("FAIL err_sticky: got %h expected %h", {flags, wr_addr}, {5'b00001, 26'd56});
    end
  endtask

  task automatic test_reset_midfill();
    start_fill(5);
    repeat (3) tick();
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b11001, 26'd8}) begin
      err_cnt++;
      $display("FAIL rst_pre: got %h expected %h", {flags, wr_addr}, {5'b11001, 26'd8});
    end
    reset = 1'b1;
    tick();
    vec_cnt++;
    if ({flags, wr_addr, fill_base_addr} !== {5'b00000, 26'd0, 26'd0}) begin
      err_cnt++;
      $display("FAIL rst_mid: got %h expected 0", {flags, wr_addr, fill_base_addr});
    end
    reset = 1'b0;
    tick();
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b00000, 26'd0}) begin
      err_cnt++;
      $display("FAIL rst_after: got %h expected 0", {flags, wr_addr});
    end
    start_fill(1);
    tick();
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b11000, 26'd0}) begin
      err_cnt++;
      $display("FAIL rst_refill_cmd: got %h expected %h", {flags, wr_addr}, {5'b11000, 26'd0});
    end
    tick();
    vec_cnt++;
    if ({flags, wr_addr} !== {5'b00100, 26'd8}) begin
      err_cnt++;
      $display("FAIL rst_refill_done: got %h expected %h", {flags, wr_addr}, {5'b00100, 26'd8});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_abort();
    test_zero_and_err();
    test_reset_midfill();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
